// File: rtl/m32b_8b.sv
// m32b_8b: word-to-byte unpacker. Takes 32-bit words on a valid/ready
// handshake and emits four bytes per word. The stream stays continuous
// across word boundaries: the next word can be accepted in the same cycle
// that the current word's last byte transfers.
module m32b_8b #(
    parameter int MSB_FIRST = 1
) (
    input  logic        clk_4f,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic [7:0]  data_out,
    output logic        valid_out,
    input  logic        ready_in,
    output logic        last_out
);

    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        valid_out_q, valid_out_d;
    logic        last_out_q, last_out_d;

    logic        acc;
    logic        xfer;
    logic [7:0]  in_byte0;
    logic [7:0]  word_bytes [4];

    // Byte k of the held word, in emission order for the chosen byte order.
    for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
        if (MSB_FIRST != 0) begin : g_msb
            assign word_bytes[gi] = word_q[31-8*gi -: 8];
        end else begin : g_lsb
            assign word_bytes[gi] = word_q[8*gi +: 8];
        end
    end

    // Byte 0 comes straight from the incoming word, so it appears one edge after accept.
    assign in_byte0 = (MSB_FIRST != 0) ? data_in[31:24] : data_in[7:0];

    assign xfer      = valid_out_q & ready_in;
    assign ready_out = !reset & (!valid_out_q | (xfer & last_out_q));
    assign acc       = valid_in & ready_out;

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign last_out  = last_out_q;

    // Next-state: a new word beats the last-byte drain; otherwise step through the held word.
    always_comb begin
        word_d      = word_q;
        idx_d       = idx_q;
        data_out_d  = data_out_q;
        valid_out_d = valid_out_q;
        last_out_d  = last_out_q;
        if (acc) begin
            word_d      = data_in;
            idx_d       = 2'd1;
            data_out_d  = in_byte0;
            valid_out_d = 1'b1;
            last_out_d  = 1'b0;
        end else if (xfer && !last_out_q) begin
            data_out_d  = word_bytes[idx_q];
            idx_d       = idx_q + 2'd1;
            last_out_d  = (idx_q == 2'd3);
        end else if (xfer && last_out_q) begin
            valid_out_d = 1'b0;
            last_out_d  = 1'b0;
        end
    end

    // State registers; reset discards any partially sent word.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            word_q      <= 32'h0;
            idx_q       <= 2'd0;
            data_out_q  <= 8'h00;
            valid_out_q <= 1'b0;
            last_out_q  <= 1'b0;
        end else begin
            word_q      <= word_d;
            idx_q       <= idx_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            last_out_q  <= last_out_d;
        end
    end

endmodule

// File: tb/tb_m32b_8b.sv
// Directed testbench for m32b_8b: one MSB-first and one LSB-first instance
// share the same stimulus; each scenario task checks its own outputs.
module tb_m32b_8b;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_in;
    logic        valid_in;
    logic        ready_in;

    logic        ready_out_m, valid_out_m, last_out_m;
    logic [7:0]  data_out_m;
    logic        ready_out_l, valid_out_l, last_out_l;
    logic [7:0]  data_out_l;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    m32b_8b #(.MSB_FIRST(1)) dut_m (
        .clk_4f(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out_m), .data_out(data_out_m), .valid_out(valid_out_m),
        .ready_in(ready_in), .last_out(last_out_m)
    );

    m32b_8b #(.MSB_FIRST(0)) dut_l (
        .clk_4f(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out_l), .data_out(data_out_l), .valid_out(valid_out_l),
        .ready_in(ready_in), .last_out(last_out_l)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; valid_in = 1'b0; ready_in = 1'b1; data_in = 32'h0;
        step(); step();
        n_cmp++; if (data_out_m !== 8'h00) begin n_bad++; $display("FAIL rst_data got %h want 00", data_out_m); end
        n_cmp++; if (valid_out_m !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", valid_out_m); end
        n_cmp++; if (last_out_m !== 1'b0) begin n_bad++; $display("FAIL rst_last got %b want 0", last_out_m); end
        n_cmp++; if (ready_out_m !== 1'b0) begin n_bad++; $display("FAIL rst_ready_in_reset got %b want 0", ready_out_m); end
        reset = 1'b0;
        #1;
        n_cmp++; if (ready_out_m !== 1'b1) begin n_bad++; $display("FAIL rst_ready_after got %b want 1", ready_out_m); end
        $display("reset done");
    endtask

    task automatic test_single();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3; exp_b[3] = 8'hD4;
        data_in = 32'hA1B2C3D4; valid_in = 1'b1; ready_in = 1'b1;
        step();
        valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            $display("single byte %0d data=%h last=%b", i, data_out_m, last_out_m);
            n_cmp++; if (data_out_m !== exp_b[i]) begin n_bad++; $display("FAIL single_data[%0d] got %h want %h", i, data_out_m, exp_b[i]); end
            n_cmp++; if (valid_out_m !== 1'b1) begin n_bad++; $display("FAIL single_valid[%0d] got %b want 1", i, valid_out_m); end
            n_cmp++; if (last_out_m !== (i == 3)) begin n_bad++; $display("FAIL single_last[%0d] got %b want %b", i, last_out_m, (i == 3)); end
            step();
        end
        n_cmp++; if (valid_out_m !== 1'b0) begin n_bad++; $display("FAIL single_idle_valid got %b want 0", valid_out_m); end
        n_cmp++; if (last_out_m !== 1'b0) begin n_bad++; $display("FAIL single_idle_last got %b want 0", last_out_m); end
    endtask

    task automatic test_back_to_back();
        data_in = 32'h01020304; valid_in = 1'b1; ready_in = 1'b1;
        #1;
        n_cmp++; if (ready_out_m !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_idle got %b want 1", ready_out_m); end
        step();
        valid_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            $display("b2b byte %0d data=%h last=%b", i, data_out_m, last_out_m);
            n_cmp++; if (data_out_m !== 8'(i + 1)) begin n_bad++; $display("FAIL b2b_data[%0d] got %h want %h", i, data_out_m, 8'(i + 1)); end
            n_cmp++; if (valid_out_m !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d] got %b want 1", i, valid_out_m); end
            n_cmp++; if (last_out_m !== (i % 4 == 3)) begin n_bad++; $display("FAIL b2b_last[%0d] got %b want %b", i, last_out_m, (i % 4 == 3)); end
            if (i == 3) begin data_in = 32'h05060708; valid_in = 1'b1; end
            #1;
            n_cmp++; if (ready_out_m !== (i % 4 == 3)) begin n_bad++; $display("FAIL b2b_ready[%0d] got %b want %b", i, ready_out_m, (i % 4 == 3)); end
            step();
            if (i == 3) valid_in = 1'b0;
        end
        n_cmp++; if (valid_out_m !== 1'b0) begin n_bad++; $display("FAIL b2b_end_valid got %b want 0", valid_out_m); end
    endtask

    task automatic test_stall();
        data_in = 32'hA1B2C3D4; valid_in = 1'b1; ready_in = 1'b1;
        step();
        valid_in = 1'b0;
        step();
        ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            $display("stall cycle %0d data=%h valid=%b", i, data_out_m, valid_out_m);
            n_cmp++; if (data_out_m !== 8'hB2) begin n_bad++; $display("FAIL stall_data[%0d] got %h want b2", i, data_out_m); end
            n_cmp++; if (valid_out_m !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d] got %b want 1", i, valid_out_m); end
            n_cmp++; if (ready_out_m !== 1'b0) begin n_bad++; $display("FAIL stall_ready[%0d] got %b want 0", i, ready_out_m); end
            step();
        end
        n_cmp++; if (data_out_m !== 8'hB2) begin n_bad++; $display("FAIL stall_hold_end got %h want b2", data_out_m); end
        ready_in = 1'b1;
        step();
        n_cmp++; if (data_out_m !== 8'hC3) begin n_bad++; $display("FAIL stall_resume got %h want c3", data_out_m); end
        step();
        n_cmp++; if (data_out_m !== 8'hD4 || last_out_m !== 1'b1) begin n_bad++; $display("FAIL stall_last got %h/%b want d4/1", data_out_m, last_out_m); end
        step();
        n_cmp++; if (valid_out_m !== 1'b0) begin n_bad++; $display("FAIL stall_idle got %b want 0", valid_out_m); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
        data_in = 32'hA1B2C3D4; valid_in = 1'b1; ready_in = 1'b1;
        step();
        valid_in = 1'b0;
        step(); step();
        n_cmp++; if (data_out_m !== 8'hC3) begin n_bad++; $display("FAIL rmid_pre got %h want c3", data_out_m); end
        reset = 1'b1;
        #1;
        n_cmp++; if (ready_out_m !== 1'b0) begin n_bad++; $display("FAIL rmid_ready got %b want 0", ready_out_m); end
        step();
        $display("reset mid-word data=%h valid=%b last=%b", data_out_m, valid_out_m, last_out_m);
        n_cmp++; if (data_out_m !== 8'h00) begin n_bad++; $display("FAIL rmid_data got %h want 00", data_out_m); end
        n_cmp++; if (valid_out_m !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got %b want 0", valid_out_m); end
        n_cmp++; if (last_out_m !== 1'b0) begin n_bad++; $display("FAIL rmid_last got %b want 0", last_out_m); end
        reset = 1'b0;
        data_in = 32'h11223344; valid_in = 1'b1;
        #1;
        n_cmp++; if (ready_out_m !== 1'b1) begin n_bad++; $display("FAIL rmid_ready_after got %b want 1", ready_out_m); end
        step();
        valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (data_out_m !== exp_b[i] || last_out_m !== (i == 3)) begin n_bad++; $display("FAIL rmid_new[%0d] got %h/%b want %h/%b", i, data_out_m, last_out_m, exp_b[i], (i == 3)); end
            step();
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hD4; exp_b[1] = 8'hC3; exp_b[2] = 8'hB2; exp_b[3] = 8'hA1;
        data_in = 32'hA1B2C3D4; valid_in = 1'b1; ready_in = 1'b1;
        step();
        valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            $display("lsb byte %0d data=%h last=%b", i, data_out_l, last_out_l);
            n_cmp++; if (data_out_l !== exp_b[i]) begin n_bad++; $display("FAIL lsb_data[%0d] got %h want %h", i, data_out_l, exp_b[i]); end
            n_cmp++; if (last_out_l !== (i == 3) || valid_out_l !== 1'b1) begin n_bad++; $display("FAIL lsb_flags[%0d] got last=%b valid=%b want last=%b valid=1", i, last_out_l, valid_out_l, (i == 3)); end
            step();
        end
        n_cmp++; if (valid_out_l !== 1'b0) begin n_bad++; $display("FAIL lsb_idle got %b want 0", valid_out_l); end
    endtask

    task automatic test_ignore_busy();
        logic [7:0]  exp_b [8];
        logic [31:0] din [4];
        exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'hCC; exp_b[3] = 8'hDD;
        exp_b[4] = 8'hCA; exp_b[5] = 8'hFE; exp_b[6] = 8'hF0; exp_b[7] = 8'h0D;
        din[0] = 32'h11111111; din[1] = 32'h22222222; din[2] = 32'hCAFEF00D; din[3] = 32'hCAFEF00D;
        data_in = 32'hAABBCCDD; valid_in = 1'b1; ready_in = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            $display("ignore byte %0d data=%h last=%b", i, data_out_m, last_out_m);
            n_cmp++; if (data_out_m !== exp_b[i] || valid_out_m !== 1'b1) begin n_bad++; $display("FAIL ign_data[%0d] got %h/%b want %h/1", i, data_out_m, valid_out_m, exp_b[i]); end
            if (i < 4) begin data_in = din[i]; valid_in = 1'b1; end
            else valid_in = 1'b0;
            step();
        end
        n_cmp++; if (valid_out_m !== 1'b0) begin n_bad++; $display("FAIL ign_idle got %b want 0", valid_out_m); end
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; ready_in = 1'b0; data_in = 32'h0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_lsb_first();
        test_ignore_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
